median_3x3: RTL and testbench

MEDIAN_3X3 -- requirements
Module: median_3x3

---
 rtl/median_3x3.sv | 148 ++++++++++++++
 tb/tb_median_3x3.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/median_3x3.sv
// 3x3 median filter with frame position tracking.
// Three-stage pipeline: row sort, column reduction, final median.
// Pixels in the two-pixel border (col<2 or row<2) are output as 0.
module median_3x3 #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iValid,
  input  logic [7:0] iData_11,
  input  logic [7:0] iData_12,
  input  logic [7:0] iData_13,
  input  logic [7:0] iData_21,
  input  logic [7:0] iData_22,
  input  logic [7:0] iData_23,
  input  logic [7:0] iData_31,
  input  logic [7:0] iData_32,
  input  logic [7:0] iData_33,
  output logic       oValid,
  output logic [7:0] oData,
  output logic       oFrameDone
);

  localparam int DATA_W = 8;
  localparam int CW     = $clog2(IMG_WIDTH);
  localparam int RW     = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  function automatic logic [DATA_W-1:0] max2(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [DATA_W-1:0] min2(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [DATA_W-1:0] max3(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                             input logic [DATA_W-1:0] c);
    return max2(max2(a, b), c);
  endfunction

  function automatic logic [DATA_W-1:0] min3(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                             input logic [DATA_W-1:0] c);
    return min2(min2(a, b), c);
  endfunction

  // Middle of three: the larger of min(a,b) and min(max(a,b),c).
  function automatic logic [DATA_W-1:0] mid3(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                             input logic [DATA_W-1:0] c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  // Packed as {max, mid, min}.
  function automatic logic [3*DATA_W-1:0] sort3(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                                input logic [DATA_W-1:0] c);
    return {max3(a, b, c), mid3(a, b, c), min3(a, b, c)};
  endfunction

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          border_in;
  logic          last_in;

  // Position flags use the counters before this pixel advances them.
  assign border_in = (col < CW'(2)) || (row < RW'(2));
  assign last_in   = (col == COL_LAST) && (row == ROW_LAST);

  // Raster position: advance on accepted pixels only, wrap at line and frame ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (iValid) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  logic [DATA_W-1:0] max_p0 [3];
  logic [DATA_W-1:0] mid_p0 [3];
  logic [DATA_W-1:0] min_p0 [3];
  logic              vld_p0, border_p0, last_p0;

  // Stage 0: sort each window row into max/mid/min.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        max_p0[i] <= '0;
        mid_p0[i] <= '0;
        min_p0[i] <= '0;
      end
      vld_p0    <= 1'b0;
      border_p0 <= 1'b0;
      last_p0   <= 1'b0;
    end else begin
      {max_p0[0], mid_p0[0], min_p0[0]} <= sort3(iData_11, iData_12, iData_13);
      {max_p0[1], mid_p0[1], min_p0[1]} <= sort3(iData_21, iData_22, iData_23);
      {max_p0[2], mid_p0[2], min_p0[2]} <= sort3(iData_31, iData_32, iData_33);
      vld_p0    <= iValid;
      border_p0 <= border_in;
      last_p0   <= last_in;
    end
  end

  logic [DATA_W-1:0] lo_p1, md_p1, hi_p1;
  logic              vld_p1, border_p1, last_p1;

  // Stage 1: max of mins, mid of mids, min of maxes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_p1     <= '0;
      md_p1     <= '0;
      hi_p1     <= '0;
      vld_p1    <= 1'b0;
      border_p1 <= 1'b0;
      last_p1   <= 1'b0;
    end else begin
      lo_p1     <= max3(min_p0[0], min_p0[1], min_p0[2]);
      md_p1     <= mid3(mid_p0[0], mid_p0[1], mid_p0[2]);
      hi_p1     <= min3(max_p0[0], max_p0[1], max_p0[2]);
      vld_p1    <= vld_p0;
      border_p1 <= border_p0;
      last_p1   <= last_p0;
    end
  end

  // Stage 2: final median (or 0 on the border); data holds between valid pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oValid     <= 1'b0;
      oData      <= '0;
      oFrameDone <= 1'b0;
    end else begin
      oValid     <= vld_p1;
      oFrameDone <= vld_p1 & last_p1;
      if (vld_p1) begin
        oData <= border_p1 ? '0 : mid3(lo_p1, md_p1, hi_p1);
      end
    end
  end

endmodule

// File: tb/tb_median_3x3.sv
// Scoreboard bench for median_3x3 on a 4x4 frame.
module tb_median_3x3;

  localparam int W = 4;
  localparam int H = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       iValid = 1'b0;
  logic [7:0] d [9];
  logic       oValid;
  logic [7:0] oData;
  logic       oFrameDone;

  median_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .iValid(iValid),
    .iData_11(d[0]), .iData_12(d[1]), .iData_13(d[2]),
    .iData_21(d[3]), .iData_22(d[4]), .iData_23(d[5]),
    .iData_31(d[6]), .iData_32(d[7]), .iData_33(d[8]),
    .oValid(oValid), .oData(oData), .oFrameDone(oFrameDone)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int data;
    bit fd;
    int due;
  } exp_t;

  exp_t sb[$];
  int   idx   = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference median: sort the nine taps, take the fifth.
  function automatic int ref_med();
    int q[$];
    for (int k = 0; k < 9; k++) q.push_back(int'(d[k]));
    q.sort();
    return q[4];
  endfunction

  function automatic logic [71:0] rnd_taps();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[71:0];
  endfunction

  function automatic logic [71:0] const_taps(input logic [7:0] v);
    return {9{v}};
  endfunction

  // One clock of stimulus; a valid pixel pushes its expected result.
  task automatic step(input bit v, input logic [71:0] tp);
    exp_t e;
    int col, row;
    @(posedge clk);
    #1;
    for (int k = 0; k < 9; k++) d[k] = tp[8*k +: 8];
    iValid = v;
    if (v) begin
      col    = idx % W;
      row    = idx / W;
      e.data = (col < 2 || row < 2) ? 0 : ref_med();
      e.fd   = (col == W - 1) && (row == H - 1);
      e.due  = cyc + 3;
      sb.push_back(e);
      idx = (idx + 1) % (W * H);
    end
  endtask

  task automatic gaps(input int maxg);
    int g;
    g = $urandom_range(maxg, 0);
    for (int i = 0; i < g; i++) step(1'b0, rnd_taps());
  endtask

  task automatic check_idle(input string name);
    n_cmp++;
    if (oValid !== 1'b0 || oData !== 8'd0 || oFrameDone !== 1'b0) begin
      n_err++;
      $display("FAIL %s: oValid=%b oData=%0d oFrameDone=%b, required 0/0/0", name, oValid, oData, oFrameDone);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      step(1'b0, rnd_taps());
      n++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d outputs pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: every presented output must match the oldest expectation, on its due cycle.
  always @(negedge clk) begin
    exp_t e;
    if (oValid === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_oValid: oData=%0d at cycle %0d, required no output", oData, cyc);
      end else begin
        e = sb.pop_front();
        if (int'(oData) != e.data || oFrameDone !== e.fd || cyc != e.due) begin
          n_err++;
          $display("FAIL pixel: oData=%0d fd=%b cycle=%0d, required oData=%0d fd=%b cycle=%0d",
                   oData, oFrameDone, cyc, e.data, e.fd, e.due);
        end
      end
    end else begin
      n_cmp++;
      if (oFrameDone !== 1'b0) begin
        n_err++;
        $display("FAIL frame_done_without_valid: oFrameDone=%b, required 0", oFrameDone);
      end
    end
  end

  initial begin
    for (int k = 0; k < 9; k++) d[k] = 8'd0;
    #1 rst_n = 1'b0;
    #2 check_idle("reset_async");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, rnd_taps());
      check_idle("idle_after_reset");
    end

    // Positions 0..9 random, then directed patterns on interior positions.
    for (int i = 0; i < 10; i++) step(1'b1, rnd_taps());
    step(1'b1, {8'd5, 8'd4, 8'd6, 8'd3, 8'd7, 8'd2, 8'd8, 8'd1, 8'd9});
    step(1'b1, {8'd0, {8{8'hFF}}});
    step(1'b1, rnd_taps());
    step(1'b1, rnd_taps());
    step(1'b1, {{4{8'hFF}}, {5{8'h00}}});
    step(1'b1, rnd_taps());

    // Flat frame back-to-back, the same frame with gaps, then a wrapped first pixel.
    for (int i = 0; i < W * H; i++) step(1'b1, const_taps(8'd100));
    for (int i = 0; i < W * H; i++) begin
      gaps(5);
      step(1'b1, const_taps(8'd100));
    end
    step(1'b1, const_taps(8'd100));
    step(1'b0, rnd_taps());
    drain();
    idx = 0;
    rst_n = 1'b0;
    #1 rst_n = 1'b1;

    // Random frames with random gaps.
    for (int i = 0; i < 3 * W * H; i++) begin
      gaps(3);
      step(1'b1, rnd_taps());
    end
    drain();

    // Reset with two pixels in flight.
    for (int i = 0; i < 5; i++) step(1'b1, rnd_taps());
    step(1'b1, rnd_taps());
    step(1'b1, rnd_taps());
    @(posedge clk);
    #1;
    rst_n  = 1'b0;
    iValid = 1'b0;
    sb.delete();
    idx = 0;
    #1 check_idle("reset_mid_pipe");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, rnd_taps());
      check_idle("no_output_after_reset");
    end
    step(1'b1, const_taps(8'd200));
    for (int i = 0; i < W * H + 3; i++) step(1'b1, rnd_taps());
    step(1'b0, rnd_taps());
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
